// File: rtl/sale_pkg.sv
// Shared types for the sale dispenser: drink codes, queued event payload, FSM encoding.
package sale_pkg;

    localparam logic [1:0] DRINK_NONE = 2'd0;
    localparam logic [1:0] DRINK_5    = 2'd1;
    localparam logic [1:0] DRINK_10   = 2'd2;
    localparam logic [1:0] DRINK_BAD  = 2'd3;

    localparam int unsigned EVT_W = 3;

    typedef struct packed {
        logic [1:0] drink;
        logic       chg;
    } sale_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VEND   = 2'd1,
        ST_CHANGE = 2'd2,
        ST_GAP    = 2'd3
    } disp_state_e;

    // An invalid code from the sale FSM carries no drink.
    function automatic logic [1:0] sanitize_drink(input logic [1:0] code);
        return (code == DRINK_BAD) ? DRINK_NONE : code;
    endfunction

endpackage

// File: rtl/sale_evt_fifo.sv
// Synchronous DEPTH-entry FIFO of sale events; a push while full is accepted when a pop
// happens in the same cycle, otherwise it is dropped and flagged on drop_o.
module sale_evt_fifo
    import sale_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  sale_evt_t push_data_i,
    input  logic      pop_i,
    output sale_evt_t pop_data_o,
    output logic      full_o,
    output logic      empty_o,
    output logic      drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    sale_evt_t       mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic [AW:0]     count_d;
    logic            push_ok;
    logic            pop_ok;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign pop_ok     = pop_i && !empty_o;
    assign push_ok    = push_i && (!full_o || pop_ok);
    assign drop_o     = push_i && full_o && !pop_ok;
    assign pop_data_o = mem_q[rd_ptr_q];

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop_ok) begin
            count_d = count_q + (AW+1)'(1);
        end else if (!push_ok && pop_ok) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/sale_dispenser.sv
// Queues sale events and drives timed drink motors / coin eject with per-type stock.
// Optional per-type sale/refund counters: define SALE_DISP_STATS_EN.
module sale_dispenser
    import sale_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned VEND_CYCLES = 8,
    parameter int unsigned CHG_CYCLES  = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned STOCK_W     = 8,
    parameter int unsigned STOCK_INIT  = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  drinks_in,
    input  logic        change_in,
    input  logic        restock,
    output logic        motor5,
    output logic        motor10,
    output logic        coin_eject,
    output logic [1:0]  refund,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic        sold_out5,
    output logic        sold_out10
`ifdef SALE_DISP_STATS_EN
    ,
    output logic [15:0] sold5_cnt,
    output logic [15:0] sold10_cnt,
    output logic [15:0] refund_cnt
`endif
);

    localparam int unsigned TMR_MAX_VC = (VEND_CYCLES > CHG_CYCLES) ? VEND_CYCLES : CHG_CYCLES;
    localparam int unsigned TMR_MAX    = (TMR_MAX_VC > GAP_CYCLES) ? TMR_MAX_VC : GAP_CYCLES;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);

    disp_state_e        state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [1:0]         cur_drink_q, cur_drink_d;
    logic               cur_chg_q, cur_chg_d;
    logic [1:0]         refund_q, refund_d;
    logic               motor5_q, motor10_q, coin_q;
    logic               overflow_q;
    logic [STOCK_W-1:0] stock5_q, stock10_q;

    logic [1:0]         cap_drink;
    sale_evt_t          cap_evt;
    logic               push;
    logic               pop;
    sale_evt_t          head;
    logic               fifo_empty;
    logic               fifo_drop;
    logic               dec5, dec10;
    logic               stock_avail;

    // Capture: every cycle with a drink or change request becomes one event.
    assign cap_drink = sanitize_drink(drinks_in);
    assign cap_evt   = '{drink: cap_drink, chg: change_in};
    assign push      = (cap_drink != DRINK_NONE) || change_in;

    sale_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (cap_evt),
        .pop_i       (pop),
        .pop_data_o  (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .drop_o      (fifo_drop)
    );

    assign stock_avail = (head.drink == DRINK_5) ? (stock5_q != '0) : (stock10_q != '0);

    // Next-state / pop / stock-decrement decode.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cur_drink_d = cur_drink_q;
        cur_chg_d   = cur_chg_q;
        refund_d    = DRINK_NONE;
        pop         = 1'b0;
        dec5        = 1'b0;
        dec10       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    cur_drink_d = head.drink;
                    cur_chg_d   = head.chg;
                    if (head.drink != DRINK_NONE && stock_avail) begin
                        dec5    = (head.drink == DRINK_5);
                        dec10   = (head.drink == DRINK_10);
                        state_d = ST_VEND;
                        timer_d = TMR_W'(VEND_CYCLES - 1);
                    end else begin
                        refund_d = head.drink;
                        if (head.chg) begin
                            state_d = ST_CHANGE;
                            timer_d = TMR_W'(CHG_CYCLES - 1);
                        end else begin
                            state_d = ST_GAP;
                            timer_d = TMR_W'(GAP_CYCLES - 1);
                        end
                    end
                end
            end
            ST_VEND: begin
                if (timer_q == '0) begin
                    if (cur_chg_q) begin
                        state_d = ST_CHANGE;
                        timer_d = TMR_W'(CHG_CYCLES - 1);
                    end else begin
                        state_d = ST_GAP;
                        timer_d = TMR_W'(GAP_CYCLES - 1);
                    end
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_CHANGE: begin
                if (timer_q == '0) begin
                    state_d = ST_GAP;
                    timer_d = TMR_W'(GAP_CYCLES - 1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            ST_GAP: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            cur_drink_q <= DRINK_NONE;
            cur_chg_q   <= 1'b0;
            refund_q    <= DRINK_NONE;
            motor5_q    <= 1'b0;
            motor10_q   <= 1'b0;
            coin_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cur_drink_q <= cur_drink_d;
            cur_chg_q   <= cur_chg_d;
            refund_q    <= refund_d;
            motor5_q    <= (state_d == ST_VEND) && (cur_drink_d == DRINK_5);
            motor10_q   <= (state_d == ST_VEND) && (cur_drink_d == DRINK_10);
            coin_q      <= (state_d == ST_CHANGE);
            overflow_q  <= overflow_q | fifo_drop;
        end
    end

    // Restock overrides a decrement landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || restock) begin
            stock5_q  <= STOCK_W'(STOCK_INIT);
            stock10_q <= STOCK_W'(STOCK_INIT);
        end else begin
            if (dec5 && stock5_q != '0)   stock5_q  <= stock5_q - STOCK_W'(1);
            if (dec10 && stock10_q != '0) stock10_q <= stock10_q - STOCK_W'(1);
        end
    end

    assign motor5     = motor5_q;
    assign motor10    = motor10_q;
    assign coin_eject = coin_q;
    assign refund     = refund_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign sold_out5  = (stock5_q == '0);
    assign sold_out10 = (stock10_q == '0);

`ifdef SALE_DISP_STATS_EN
    logic [15:0] sold5_q, sold10_q, refund_cnt_q;

    // Saturating counters, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sold5_q      <= '0;
            sold10_q     <= '0;
            refund_cnt_q <= '0;
        end else begin
            if (dec5 && sold5_q != 16'hFFFF)                      sold5_q      <= sold5_q + 16'd1;
            if (dec10 && sold10_q != 16'hFFFF)                    sold10_q     <= sold10_q + 16'd1;
            if (refund_d != DRINK_NONE && refund_cnt_q != 16'hFFFF) refund_cnt_q <= refund_cnt_q + 16'd1;
        end
    end

    assign sold5_cnt  = sold5_q;
    assign sold10_cnt = sold10_q;
    assign refund_cnt = refund_cnt_q;
`endif

endmodule

// File: tb/tb_sale_dispenser.sv
// Directed bench for sale_dispenser; "cycle c" means c rising edges after the input cycle.
module tb_sale_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] drinks_in;
    logic       change_in;
    logic       restock;
    logic       motor5, motor10, coin_eject;
    logic [1:0] refund;
    logic       busy, fifo_full, overflow, sold_out5, sold_out10;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sale_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .drinks_in  (drinks_in),
        .change_in  (change_in),
        .restock    (restock),
        .motor5     (motor5),
        .motor10    (motor10),
        .coin_eject (coin_eject),
        .refund     (refund),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .sold_out5  (sold_out5),
        .sold_out10 (sold_out10)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int i = 0; i < max_cyc && busy; i++) tick();
        chk("wait_idle", busy, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   edges;
        logic prev;

        rst = 1'b1; drinks_in = 2'd0; change_in = 1'b0; restock = 1'b0;
        repeat (2) tick();
        chk("rst_motor5", motor5, 0);
        chk("rst_motor10", motor10, 0);
        chk("rst_coin", coin_eject, 0);
        chk("rst_refund", refund, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_sold_out5", sold_out5, 0);
        chk("rst_sold_out10", sold_out10, 0);
        rst = 1'b0;

        // single 5$ drink, no change
        drinks_in = 2'd1; tick(); drinks_in = 2'd0;
        for (int c = 1; c <= 12; c++) begin
            chk($sformatf("t1_motor5_c%0d", c), motor5, (c >= 2 && c <= 9));
            chk($sformatf("t1_coin_c%0d", c), coin_eject, 0);
            chk($sformatf("t1_busy_c%0d", c), busy, (c <= 11));
            if (c < 12) tick();
        end
        chk("t1_stock5", dut.stock5_q, 19);

        // 10$ drink with change: motor10 then coin eject back to back
        drinks_in = 2'd2; change_in = 1'b1; tick(); drinks_in = 2'd0; change_in = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            chk($sformatf("t2_motor10_c%0d", c), motor10, (c >= 2 && c <= 9));
            chk($sformatf("t2_coin_c%0d", c), coin_eject, (c >= 10 && c <= 13));
            chk($sformatf("t2_overlap_c%0d", c), motor10 & coin_eject, 0);
            chk($sformatf("t2_busy_c%0d", c), busy, (c <= 15));
            if (c < 16) tick();
        end
        chk("t2_stock10", dut.stock10_q, 19);

        // 6 back-to-back sales into a 4-deep FIFO: one dropped
        edges = 0; prev = 1'b0;
        drinks_in = 2'd1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) drinks_in = 2'd0;
            if (motor5 && !prev) edges++;
            prev = motor5;
            if (c == 2) chk("t3_motor5_c2", motor5, 1);
            if (c == 5) chk("t3_full_c5", fifo_full, 1);
            if (c == 6) chk("t3_overflow_c6", overflow, 1);
        end
        for (int i = 0; i < 100 && busy; i++) begin
            tick();
            if (motor5 && !prev) edges++;
            prev = motor5;
        end
        chk("t3_idle", busy, 0);
        chk("t3_served", edges, 5);
        chk("t3_overflow_sticky", overflow, 1);
        chk("t3_stock5", dut.stock5_q, 14);

        // reset clears overflow, then drain 5$ stock to zero
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t4_overflow_cleared", overflow, 0);
        chk("t4_stock5_init", dut.stock5_q, 20);
        restock = 1'b1; tick(); restock = 1'b0;
        for (int n = 0; n < 20; n++) begin
            drinks_in = 2'd1; tick(); drinks_in = 2'd0;
            wait_idle(30);
        end
        chk("t4_sold_out5", sold_out5, 1);
        chk("t4_sold_out10", sold_out10, 0);
        drinks_in = 2'd1; change_in = 1'b1; tick(); drinks_in = 2'd0; change_in = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t4_motor5_c%0d", c), motor5, 0);
            chk($sformatf("t4_refund_c%0d", c), refund, (c == 2) ? 1 : 0);
            chk($sformatf("t4_coin_c%0d", c), coin_eject, (c >= 2 && c <= 5));
            chk($sformatf("t4_busy_c%0d", c), busy, (c <= 7));
            if (c < 8) tick();
        end
        chk("t4_stock5_no_wrap", dut.stock5_q, 0);
        chk("t4_sold_out5_hold", sold_out5, 1);

        // restock in the same cycle as a vend decrement
        restock = 1'b1; tick(); restock = 1'b0;
        chk("t5_sold_out5_cleared", sold_out5, 0);
        drinks_in = 2'd1; tick(); drinks_in = 2'd0; wait_idle(30);
        drinks_in = 2'd2; tick(); drinks_in = 2'd0; wait_idle(30);
        chk("t5_stock5_pre", dut.stock5_q, 19);
        chk("t5_stock10_pre", dut.stock10_q, 19);
        drinks_in = 2'd1; tick(); drinks_in = 2'd0;
        restock = 1'b1; tick(); restock = 1'b0;
        chk("t5_motor5_c2", motor5, 1);
        chk("t5_stock5", dut.stock5_q, 20);
        chk("t5_stock10", dut.stock10_q, 20);
        wait_idle(30);

        // reset mid-VEND with a full FIFO and overflow set
        drinks_in = 2'd1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 6) drinks_in = 2'd0;
        end
        tick();
        chk("t6_motor5_pre", motor5, 1);
        chk("t6_full_pre", fifo_full, 1);
        chk("t6_overflow_pre", overflow, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_motor5", motor5, 0);
        chk("t6_motor10", motor10, 0);
        chk("t6_coin", coin_eject, 0);
        chk("t6_busy", busy, 0);
        chk("t6_full", fifo_full, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_stock5", dut.stock5_q, 20);
        repeat (4) tick();
        chk("t6_motor5_after", motor5, 0);
        chk("t6_busy_after", busy, 0);

        // invalid drink code: alone it is ignored, with change it becomes a change event
        drinks_in = 2'd3; tick(); drinks_in = 2'd0;
        chk("t7_busy_c1", busy, 0);
        tick();
        chk("t7_motors_c2", {motor5, motor10, coin_eject}, 0);
        drinks_in = 2'd3; change_in = 1'b1; tick(); drinks_in = 2'd0; change_in = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("t7_coin_c%0d", c), coin_eject, (c >= 2 && c <= 5));
            chk($sformatf("t7_motors_c%0d", c), {motor5, motor10}, 0);
            chk($sformatf("t7_refund_c%0d", c), refund, 0);
            chk($sformatf("t7_busy_c%0d", c), busy, (c <= 7));
            if (c < 8) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
